// File: rtl/axis_pkt_arbiter_pkg.sv
// Shared types and helpers for the packet-granular AXI-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 32'sd1) % n;
  endfunction

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// Bundle of the N slave streams and the single merged master stream.
interface axis_pkt_arbiter_if #(
  parameter int N_SRC       = 2,
  parameter int TDATA_WIDTH = 32,
  parameter int ID_WIDTH    = $clog2(N_SRC)
);
  logic [N_SRC-1:0]                 s_tvalid;
  logic [N_SRC-1:0]                 s_tready;
  logic [N_SRC*TDATA_WIDTH-1:0]     s_tdata;
  logic [N_SRC*TDATA_WIDTH/8-1:0]   s_tkeep;
  logic [N_SRC-1:0]                 s_tlast;
  logic [N_SRC-1:0]                 s_tuser;
  logic                             m_tvalid;
  logic                             m_tready;
  logic [TDATA_WIDTH-1:0]           m_tdata;
  logic [TDATA_WIDTH/8-1:0]         m_tkeep;
  logic                             m_tlast;
  logic                             m_tuser;
  logic [ID_WIDTH-1:0]              m_tid;

  // Arbiter side: consumes the source streams, produces the merged stream.
  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_tid
  );

  // Environment side: drives the sources and sinks the merged stream.
  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_tid
  );
endinterface

// File: rtl/axis_pkt_arbiter_rr_picker.sv
// Round-robin picker: rotate requests so the source after last_grant sits at
// bit 0, take the lowest set bit, then rotate the index back.
module rr_picker
  import axis_arb_pkg::*;
#(
  parameter int N_SRC    = 2,
  parameter int ID_WIDTH = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0]    req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any_req
);
  logic [N_SRC-1:0] rotated;
  int               start_idx;
  int               offset;

  // Rotate, priority-encode lowest request, un-rotate.
  always_comb begin
    start_idx = wrap_inc(int'(last_grant), N_SRC);
    rotated   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      rotated[i] = req[(i + start_idx) % N_SRC];
    end
    offset = 0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      offset = rotated[i] ? i : offset;
    end
    winner  = ID_WIDTH'((offset + start_idx) % N_SRC);
    any_req = |req;
  end
endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin merge of N AXI-Stream sources onto one sink.
// A grant is held from the first beat through the tlast beat; every output
// beat carries the index of the source that produced it.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N_SRC       = 2,
  parameter int TDATA_WIDTH = 32,
  parameter int ID_WIDTH    = $clog2(N_SRC)
) (
  input  logic             aclk,
  input  logic             aresetn,
  axis_pkt_arbiter_if.slave bus
);
  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;

  arb_state_t              state;
  arb_state_t              next_state;
  logic [ID_WIDTH-1:0]     grant;
  logic [ID_WIDTH-1:0]     last_grant;
  logic [ID_WIDTH-1:0]     winner;
  logic                    any_req;
  logic                    out_free;
  logic                    accept;
  logic [N_SRC-1:0]        s_ready;
  logic                    sel_valid;
  logic [TDATA_WIDTH-1:0]  sel_data;
  logic [KEEP_WIDTH-1:0]   sel_keep;
  logic                    sel_last;
  logic                    sel_user;
  logic                    out_valid;
  logic [TDATA_WIDTH-1:0]  out_data;
  logic [KEEP_WIDTH-1:0]   out_keep;
  logic                    out_last;
  logic                    out_user;
  logic [ID_WIDTH-1:0]     out_id;

  rr_picker #(
    .N_SRC   (N_SRC),
    .ID_WIDTH(ID_WIDTH)
  ) u_picker (
    .req       (bus.s_tvalid),
    .last_grant(last_grant),
    .winner    (winner),
    .any_req   (any_req)
  );

  // Mux the granted source and open its ready only when the output slot frees.
  always_comb begin
    out_free  = !out_valid || bus.m_tready;
    sel_valid = bus.s_tvalid[grant];
    sel_data  = bus.s_tdata[int'(grant)*TDATA_WIDTH +: TDATA_WIDTH];
    sel_keep  = bus.s_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
    sel_last  = bus.s_tlast[grant];
    sel_user  = bus.s_tuser[grant];
    s_ready   = '0;
    if (state == BUSY) begin
      s_ready[grant] = out_free;
    end else begin
      s_ready = '0;
    end
    accept = (state == BUSY) && sel_valid && out_free;
  end

  // Next state: arbitrate in IDLE, return to IDLE once tlast is taken.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (any_req) next_state = BUSY;
        else         next_state = IDLE;
      end
      BUSY: begin
        if (accept && sel_last) next_state = IDLE;
        else                    next_state = BUSY;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= next_state;
  end

  // Grant latch on arbitration and round-robin pointer update on packet end.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant      <= '0;
      last_grant <= ID_WIDTH'(N_SRC - 1);
    end else begin
      if (state == IDLE && any_req) grant <= winner;
      if (accept && sel_last)       last_grant <= grant;
    end
  end

  // Single-stage output register: load on accept, drop valid once drained.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
      out_id    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_keep  <= sel_keep;
      out_last  <= sel_last;
      out_user  <= sel_user;
      out_id    <= grant;
    end else if (bus.m_tready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.s_tready = s_ready;
  assign bus.m_tvalid = out_valid;
  assign bus.m_tdata  = out_data;
  assign bus.m_tkeep  = out_keep;
  assign bus.m_tlast  = out_last;
  assign bus.m_tuser  = out_user;
  assign bus.m_tid    = out_id;
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: a 2-source and a 4-source instance,
// per-source beat lists feeding the inputs and a sink-side beat recorder.
module tb_axis_pkt_arbiter;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } beat_t;
  typedef struct packed {
    beat_t      b;
    logic [1:0] id;
  } obs_t;

  logic aclk;
  logic aresetn;
  int   tests;
  int   fails;

  axis_pkt_arbiter_if #(.N_SRC(2), .TDATA_WIDTH(32)) if2();
  axis_pkt_arbiter_if #(.N_SRC(4), .TDATA_WIDTH(32)) if4();

  axis_pkt_arbiter #(.N_SRC(2), .TDATA_WIDTH(32)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .bus(if2.slave)
  );
  axis_pkt_arbiter #(.N_SRC(4), .TDATA_WIDTH(32)) dut4 (
    .aclk(aclk), .aresetn(aresetn), .bus(if4.slave)
  );

  beat_t      mem2 [2][32];
  int         wr2  [2];
  int         rd2  [2];
  logic [1:0] hold2;
  beat_t      mem4 [4][32];
  int         wr4  [4];
  int         rd4  [4];
  obs_t       o2[$];
  obs_t       o4[$];
  obs_t       ob2;
  obs_t       ob4;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Record each beat the sink takes (sampled mid-cycle, transfers next edge).
  always @(negedge aclk) begin
    if (aresetn && if2.m_tvalid && if2.m_tready) begin
      ob2.b  = {if2.m_tdata, if2.m_tkeep, if2.m_tlast, if2.m_tuser};
      ob2.id = 2'(if2.m_tid);
      o2.push_back(ob2);
    end
    if (aresetn && if4.m_tvalid && if4.m_tready) begin
      ob4.b  = {if4.m_tdata, if4.m_tkeep, if4.m_tlast, if4.m_tuser};
      ob4.id = if4.m_tid;
      o4.push_back(ob4);
    end
  end

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if2.s_tvalid[i]        = (rd2[i] < wr2[i]) && !hold2[i];
      if2.s_tdata[i*32 +: 32] = mem2[i][rd2[i]].d;
      if2.s_tkeep[i*4 +: 4]   = mem2[i][rd2[i]].k;
      if2.s_tlast[i]         = mem2[i][rd2[i]].l;
      if2.s_tuser[i]         = mem2[i][rd2[i]].u;
    end
    for (int i = 0; i < 4; i++) begin
      if4.s_tvalid[i]        = (rd4[i] < wr4[i]);
      if4.s_tdata[i*32 +: 32] = mem4[i][rd4[i]].d;
      if4.s_tkeep[i*4 +: 4]   = mem4[i][rd4[i]].k;
      if4.s_tlast[i]         = mem4[i][rd4[i]].l;
      if4.s_tuser[i]         = mem4[i][rd4[i]].u;
    end
  endtask

  task automatic clear();
    for (int i = 0; i < 32; i++) begin
      for (int s = 0; s < 2; s++) mem2[s][i] = '0;
      for (int s = 0; s < 4; s++) mem4[s][i] = '0;
    end
    for (int s = 0; s < 2; s++) begin wr2[s] = 0; rd2[s] = 0; end
    for (int s = 0; s < 4; s++) begin wr4[s] = 0; rd4[s] = 0; end
    hold2 = 2'b00;
    o2.delete();
    o4.delete();
  endtask

  task automatic push2(input int s, input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    mem2[s][wr2[s]] = {d, k, l, u};
    wr2[s]++;
  endtask

  task automatic push4(input int s, input logic [31:0] d, input logic l);
    mem4[s][wr4[s]] = {d, 4'hF, l, 1'b0};
    wr4[s]++;
  endtask

  // One clock: note handshakes mid-cycle, advance sources after the edge.
  task automatic cycle();
    logic [1:0] f2;
    logic [3:0] f4;
    @(negedge aclk);
    f2 = if2.s_tvalid & if2.s_tready;
    f4 = if4.s_tvalid & if4.s_tready;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 2; i++) if (f2[i]) rd2[i]++;
    for (int i = 0; i < 4; i++) if (f4[i]) rd4[i]++;
    drive();
  endtask

  task automatic run_until(input int n2, input int n4);
    int b = 0;
    while ((o2.size() < n2 || o4.size() < n4) && b < 200) begin
      cycle();
      b++;
    end
    repeat (2) cycle();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear();
    drive();
    repeat (2) cycle();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    repeat (2) @(posedge aclk);
    #1;
    tests++; if (if2.m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_m_tvalid2: got %b expected 0", if2.m_tvalid); end
    tests++; if (if2.s_tready !== 2'b00) begin fails++; $display("FAIL reset_s_tready2: got %b expected 00", if2.s_tready); end
    tests++; if (if2.m_tdata !== 32'h0) begin fails++; $display("FAIL reset_m_tdata2: got %h expected 0", if2.m_tdata); end
    tests++; if (if4.m_tvalid !== 1'b0 || if4.s_tready !== 4'h0) begin fails++; $display("FAIL reset_dut4: got valid=%b ready=%b expected 0/0000", if4.m_tvalid, if4.s_tready); end
    tests++; if (if4.m_tid !== 2'd0) begin fails++; $display("FAIL reset_m_tid4: got %0d expected 0", if4.m_tid); end
    aresetn = 1'b1;
  endtask

  task automatic test_single();
    clear();
    if2.m_tready = 1'b1;
    push2(0, 32'h11, 4'hF, 1'b0, 1'b0);
    push2(0, 32'h22, 4'h3, 1'b0, 1'b1);
    push2(0, 32'h33, 4'h1, 1'b1, 1'b0);
    drive();
    #1;
    tests++; if (if2.s_tready !== 2'b00) begin fails++; $display("FAIL single_idle_ready: got %b expected 00", if2.s_tready); end
    cycle();
    tests++; if (if2.m_tvalid !== 1'b0 || if2.s_tready !== 2'b01) begin fails++; $display("FAIL single_arb: got valid=%b ready=%b expected 0/01", if2.m_tvalid, if2.s_tready); end
    cycle();
    tests++; if ({if2.m_tvalid, if2.m_tdata, if2.m_tkeep, if2.m_tlast, if2.m_tid} !== {1'b1, 32'h11, 4'hF, 1'b0, 1'b0}) begin fails++; $display("FAIL single_beat1: got v=%b d=%h k=%h l=%b id=%0d expected 1/11/f/0/0", if2.m_tvalid, if2.m_tdata, if2.m_tkeep, if2.m_tlast, if2.m_tid); end
    cycle();
    tests++; if ({if2.m_tvalid, if2.m_tdata, if2.m_tkeep, if2.m_tuser, if2.m_tlast} !== {1'b1, 32'h22, 4'h3, 1'b1, 1'b0}) begin fails++; $display("FAIL single_beat2: got v=%b d=%h k=%h u=%b l=%b expected 1/22/3/1/0", if2.m_tvalid, if2.m_tdata, if2.m_tkeep, if2.m_tuser, if2.m_tlast); end
    cycle();
    tests++; if ({if2.m_tvalid, if2.m_tdata, if2.m_tkeep, if2.m_tuser, if2.m_tlast} !== {1'b1, 32'h33, 4'h1, 1'b0, 1'b1}) begin fails++; $display("FAIL single_beat3: got v=%b d=%h k=%h u=%b l=%b expected 1/33/1/0/1", if2.m_tvalid, if2.m_tdata, if2.m_tkeep, if2.m_tuser, if2.m_tlast); end
    cycle();
    tests++; if (if2.m_tvalid !== 1'b0 || if2.s_tready !== 2'b00) begin fails++; $display("FAIL single_drain: got valid=%b ready=%b expected 0/00", if2.m_tvalid, if2.s_tready); end
  endtask

  task automatic test_fairness();
    int k; int s; int p; int b;
    logic [31:0] exp_d;
    do_reset();
    if2.m_tready = 1'b1;
    for (int pp = 0; pp < 3; pp++)
      for (int ss = 0; ss < 2; ss++)
        for (int bb = 0; bb < 2; bb++)
          push2(ss, 32'hF000_0000 | 32'(ss*256 + pp*16 + bb), 4'hF, bb == 1, 1'b0);
    drive();
    run_until(12, 0);
    tests++; if (o2.size() !== 12) begin fails++; $display("FAIL fair_count: got %0d beats expected 12", o2.size()); end
    for (int j = 0; j < 12 && j < o2.size(); j++) begin
      k = j / 2; s = k % 2; p = k / 2; b = j % 2;
      exp_d = 32'hF000_0000 | 32'(s*256 + p*16 + b);
      tests++;
      if (o2[j].id !== 2'(s) || o2[j].b.d !== exp_d || o2[j].b.l !== (b == 1)) begin
        fails++;
        $display("FAIL fair_beat%0d: got id=%0d d=%h l=%b expected id=%0d d=%h l=%b", j, o2[j].id, o2[j].b.d, o2[j].b.l, s, exp_d, b == 1);
      end
    end
  endtask

  task automatic test_backpressure();
    clear();
    if2.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) push2(0, 32'h41 + 32'(i), 4'hF, i == 3, 1'b0);
    drive();
    repeat (3) cycle();
    tests++; if (if2.m_tdata !== 32'h42) begin fails++; $display("FAIL bp_pre: got %h expected 42", if2.m_tdata); end
    if2.m_tready = 1'b0;
    #1;
    tests++; if (if2.s_tready !== 2'b00) begin fails++; $display("FAIL bp_ready: got %b expected 00", if2.s_tready); end
    for (int c = 0; c < 3; c++) begin
      cycle();
      tests++;
      if (if2.m_tvalid !== 1'b1 || if2.m_tdata !== 32'h42 || if2.s_tready !== 2'b00) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%b d=%h r=%b expected 1/42/00", c, if2.m_tvalid, if2.m_tdata, if2.s_tready);
      end
    end
    if2.m_tready = 1'b1;
    run_until(4, 0);
    tests++; if (o2.size() !== 4) begin fails++; $display("FAIL bp_count: got %0d expected 4", o2.size()); end
    for (int j = 0; j < 4 && j < o2.size(); j++) begin
      tests++;
      if (o2[j].b.d !== 32'h41 + 32'(j) || o2[j].b.l !== (j == 3) || o2[j].id !== 2'd0) begin
        fails++;
        $display("FAIL bp_beat%0d: got d=%h l=%b id=%0d expected d=%h l=%b id=0", j, o2[j].b.d, o2[j].b.l, o2[j].id, 32'h41 + 32'(j), j == 3);
      end
    end
  endtask

  task automatic test_stalled();
    logic [31:0] exp_d [6];
    logic [1:0]  exp_id [6];
    exp_d  = '{32'h51, 32'h52, 32'h53, 32'h54, 32'h61, 32'h62};
    exp_id = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    clear();
    if2.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) push2(1, 32'h51 + 32'(i), 4'hF, i == 3, 1'b0);
    push2(0, 32'h61, 4'hF, 1'b0, 1'b0);
    push2(0, 32'h62, 4'hF, 1'b1, 1'b0);
    drive();
    cycle();
    tests++; if (if2.s_tready !== 2'b10) begin fails++; $display("FAIL stall_grant: got %b expected 10", if2.s_tready); end
    cycle();
    hold2[1] = 1'b1;
    drive();
    for (int c = 0; c < 5; c++) begin
      cycle();
      tests++;
      if (if2.s_tready !== 2'b10) begin fails++; $display("FAIL stall_hold%0d: got ready=%b expected 10", c, if2.s_tready); end
    end
    hold2[1] = 1'b0;
    drive();
    run_until(6, 0);
    tests++; if (o2.size() !== 6) begin fails++; $display("FAIL stall_count: got %0d expected 6", o2.size()); end
    for (int j = 0; j < 6 && j < o2.size(); j++) begin
      tests++;
      if (o2[j].b.d !== exp_d[j] || o2[j].id !== exp_id[j]) begin
        fails++;
        $display("FAIL stall_beat%0d: got d=%h id=%0d expected d=%h id=%0d", j, o2[j].b.d, o2[j].id, exp_d[j], exp_id[j]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_a [4];
    logic [1:0] exp_b [8];
    exp_a = '{2'd0, 2'd3, 2'd0, 2'd3};
    exp_b = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    clear();
    if4.m_tready = 1'b1;
    push4(0, 32'h01, 1'b1); push4(0, 32'h02, 1'b1);
    push4(3, 32'h31, 1'b1); push4(3, 32'h32, 1'b1);
    drive();
    run_until(0, 4);
    tests++; if (o4.size() !== 4) begin fails++; $display("FAIL wrap2_count: got %0d expected 4", o4.size()); end
    for (int j = 0; j < 4 && j < o4.size(); j++) begin
      tests++;
      if (o4[j].id !== exp_a[j]) begin fails++; $display("FAIL wrap2_pkt%0d: got id=%0d expected %0d", j, o4[j].id, exp_a[j]); end
    end
    clear();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 4; s++) push4(s, 32'h80 + 32'(s*16 + p), 1'b1);
    drive();
    run_until(0, 8);
    tests++; if (o4.size() !== 8) begin fails++; $display("FAIL wrap4_count: got %0d expected 8", o4.size()); end
    for (int j = 0; j < 8 && j < o4.size(); j++) begin
      tests++;
      if (o4[j].id !== exp_b[j] || o4[j].b.d !== 32'h80 + 32'(int'(exp_b[j])*16 + j/4)) begin
        fails++;
        $display("FAIL wrap4_pkt%0d: got id=%0d d=%h expected id=%0d", j, o4[j].id, o4[j].b.d, exp_b[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_id [4];
    exp_id = '{2'd0, 2'd0, 2'd1, 2'd1};
    clear();
    if2.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) push2(1, 32'h71 + 32'(i), 4'hF, i == 3, 1'b0);
    drive();
    repeat (3) cycle();
    tests++; if (if2.m_tdata !== 32'h72 || if2.m_tid !== 1'b1) begin fails++; $display("FAIL rmid_pre: got d=%h id=%0d expected 72/1", if2.m_tdata, if2.m_tid); end
    aresetn = 1'b0;
    #1;
    tests++;
    if (if2.m_tvalid !== 1'b0 || if2.s_tready !== 2'b00 || if2.m_tdata !== 32'h0) begin
      fails++;
      $display("FAIL rmid_clear: got v=%b r=%b d=%h expected 0/00/0", if2.m_tvalid, if2.s_tready, if2.m_tdata);
    end
    cycle();
    aresetn = 1'b1;
    clear();
    push2(0, 32'hA1, 4'hF, 1'b0, 1'b0); push2(0, 32'hA2, 4'hF, 1'b1, 1'b0);
    push2(1, 32'hB1, 4'hF, 1'b0, 1'b0); push2(1, 32'hB2, 4'hF, 1'b1, 1'b0);
    drive();
    run_until(4, 0);
    tests++; if (o2.size() !== 4) begin fails++; $display("FAIL rmid_count: got %0d expected 4", o2.size()); end
    for (int j = 0; j < 4 && j < o2.size(); j++) begin
      tests++;
      if (o2[j].id !== exp_id[j]) begin fails++; $display("FAIL rmid_beat%0d: got id=%0d expected %0d", j, o2[j].id, exp_id[j]); end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    aresetn = 1'b0;
    if2.m_tready = 1'b0;
    if4.m_tready = 1'b0;
    clear();
    drive();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_stalled();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-granular round-robin arbiter that merges N AXI-Stream sources onto one AXI-Stream sink. It sits in front of the shared AES core input so that several requesters (key-load, encrypt and decrypt command streams) can share a single datapath without interleaving beats of different packets. A grant is held from the first beat to the `tlast` beat, and each forwarded beat is tagged with the index of its source.

## Interface
Parameters:
- `N_SRC`, 2: number of slave streams (≥2).
- `TDATA_WIDTH`, 32: tdata width in bits (multiple of 8).
- `ID_WIDTH`, `$clog2(N_SRC)`: width of the source tag (derived; do not override).

Ports:
- `aclk`  in  1  clock. One clock domain; all ports are sampled on its rising edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `s_tvalid`  in  N_SRC  per-source valid.
- `s_tready`  out  N_SRC  per-source ready.
- `s_tdata`  in  N_SRC*TDATA_WIDTH  per-source data. Source i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH].
- `s_tkeep`  in  N_SRC*TDATA_WIDTH/8  per-source byte enables, packed the same way.
- `s_tlast`  in  N_SRC  per-source end of packet.
- `s_tuser`  in  N_SRC  per-source user bit.
- `m_tvalid`  out  1  output valid.
- `m_tready`  in  1  output ready.
- `m_tdata`  out  TDATA_WIDTH  output data.
- `m_tkeep`  out  TDATA_WIDTH/8  output byte enables.
- `m_tlast`  out  1  output end of packet.
- `m_tuser`  out  1  output user bit.
- `m_tid`  out  ID_WIDTH  index of the source that produced the current output beat.

## Operation
- FSM states: IDLE and BUSY.
- Reset values: state=IDLE, `last_grant`=N_SRC-1, `grant`=0, `s_tready`=0, `m_tvalid`=0. All m_* data outputs are 0.
- IDLE behaviour:
  - `s_tready` is all-zero.
  - If any `s_tvalid` is high, the winner is the first asserted source found scanning last_grant+1, last_grant+2, … modulo N_SRC.
  - On that edge: grant<=winner, state<=BUSY.
  - If no `s_tvalid` is high, the FSM stays in IDLE.
- BUSY behaviour:
  - `s_tready[grant]` = `!m_tvalid || m_tready`. All other `s_tready` bits are 0.
  - A beat is accepted when `s_tvalid[grant] && s_tready[grant]`. The accepted beat is loaded into the output register, with `m_tid`<=grant.
  - If the accepted beat has `tlast`=1: last_grant<=grant, state<=IDLE.
- No preemption. If the granted source drops `tvalid` mid-packet, the grant is held indefinitely. Other requesters wait.
- Output register:
  - On `m_tvalid && m_tready` with no new beat accepted, `m_tvalid`<=0.
  - While `m_tvalid && !m_tready`, all m_* outputs hold stable.
- Payload is unmodified. `tkeep` and `tuser` pass through per beat. The block does not check tkeep contiguity.
- Reset mid-packet: the partial packet is discarded, the output register clears, and round-robin restarts from source 0.

## Timing
- Arbitration costs 1 cycle: for a new packet, the first `s_tready` asserts at earliest the cycle after IDLE sees `s_tvalid`.
- Latency: a beat accepted at edge k is visible on m_* after edge k (registered, one stage).
- Throughput in BUSY with `m_tready` held high: 1 beat/cycle.
- Packet gap: at least 1 idle cycle on the input side between consecutive packets (the tlast beat edge, then the IDLE arbitration edge).
- Wrap-around: pointer arithmetic is modulo N_SRC. After source N_SRC-1, source 0 has top priority.
- Simultaneous events:
  - Output drain and new beat acceptance in the same cycle loads the new beat; `m_tvalid` stays 1.
  - `tlast` acceptance and another source's `tvalid` rising in the same cycle: the other source is considered in the next IDLE cycle.

## Structure
- Package `axis_arb_pkg` holds the state enum `arb_state_t` {IDLE, BUSY}.
- Sub-module `rr_picker` (combinational): inputs are the request vector and last_grant; outputs are winner index and `any_req`. It is implemented as a rotate, priority-encode, un-rotate.
- The top module holds the FSM, the grant registers, the output register and the input muxing.

## Test plan
- **Single source:** N_SRC=2, src0 sends a 3-beat packet (0x11,0x22,0x33; tlast on 0x33), `m_tready`=1 → m_tdata 0x11,0x22,0x33 on consecutive cycles, `m_tid`=0, `m_tlast` on beat 3, first beat 2 cycles after `s_tvalid`.
- **Fairness:** src0 and src1 continuously offer 2-beat packets → output packet tids alternate 0,1,0,1, starting with 0 after reset. There is never an interleaving within a packet.
- **Backpressure:** during a 4-beat packet, `m_tready`=0 for 3 cycles on beat 2 → m_* hold beat 2 stable, `s_tready[grant]`=0, no beat is lost or duplicated.
- **Stalled source:** src1 drops `tvalid` for 5 cycles mid-packet while src0 requests → src0 is not granted until src1's tlast beat is accepted.
- **Wrap-around:** N_SRC=4, only sources 3 and 0 request → grants go 0,3,0,3. With all four requesting → 0,1,2,3,0.
- **Reset mid-packet:** assert `aresetn`=0 on beat 2 of a src1 packet → `m_tvalid`=0 and `s_tready`=0 immediately. After release, a src0/src1 contention grants src0 first.
